spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_slave_if.sv | 49 ++++
 rtl/spi_sync.sv | 43 ++++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_pkg                                                         |
// | Purpose  : Shared defaults and FSM state encoding for the SPI slave.      |
// |            c_data_w      - default frame width in bits                    |
// |            c_sync_stages - default synchronizer depth                     |
// |            state_t       - slave FSM states (IDLE, SHIFT)                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package spi_pkg;

    localparam int c_data_w      = 8;
    localparam int c_sync_stages = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave_if                                                    |
// | Purpose  : Bundles the SPI slave's configuration, TX/RX byte streams,     |
// |            status and serial bus pins.                                     |
// |            cpol_i/cpha_i           - SPI mode, static while ss_ni is low  |
// |            tx_data_i/valid/ready   - byte handshake into the TX buffer    |
// |            rx_data_o/rx_valid_o    - received byte and its update pulse   |
// |            tx_underrun_o, busy_o   - status                                |
// |            sclk_i/ss_ni/mosi_i     - asynchronous bus from the master     |
// |            miso_o/miso_oe_o        - serial data out and its enable       |
// |            Modport slave is the design view, master the user/bus view.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = c_data_w
) ();

    logic              cpol_i;
    logic              cpha_i;
    logic [DATA_W-1:0] tx_data_i;
    logic              tx_valid_i;
    logic              tx_ready_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_valid_o;
    logic              tx_underrun_o;
    logic              busy_o;
    logic              sclk_i;
    logic              ss_ni;
    logic              mosi_i;
    logic              miso_o;
    logic              miso_oe_o;

    modport slave (
        input  cpol_i, cpha_i, tx_data_i, tx_valid_i, sclk_i, ss_ni, mosi_i,
        output tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o,
               miso_o, miso_oe_o
    );

    modport master (
        output cpol_i, cpha_i, tx_data_i, tx_valid_i, sclk_i, ss_ni, mosi_i,
        input  tx_ready_o, rx_data_o, rx_valid_o, tx_underrun_o, busy_o,
               miso_o, miso_oe_o
    );

endinterface
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_sync                                                        |
// | Purpose  : Flop-chain synchronizer of configurable depth for one          |
// |            asynchronous input.                                             |
// |            clk_i   - destination clock                                     |
// |            rst_ni  - asynchronous active-low reset (chain -> RST_VAL)      |
// |            d_i     - asynchronous input                                    |
// |            q_o     - synchronized output                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES  = c_sync_stages,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) r_chain <= RST_VAL;
                else         r_chain <= d_i;
            end
        end else begin : g_multi
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) r_chain <= {STAGES{RST_VAL}};
                else         r_chain <= {r_chain[STAGES-2:0], d_i};
            end
        end
    endgenerate

    assign q_o = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_slave                                                       |
// | Purpose  : SPI slave, all four CPOL/CPHA modes, MSB first, with a one-     |
// |            entry TX buffer and back-to-back frames while ss_n stays low.  |
// |            SCLK is oversampled by clk_i (half-period >= SYNC_STAGES+2).   |
// |            clk_i   - system clock                                          |
// |            rst_ni  - asynchronous active-low reset                         |
// |            bus     - spi_slave_if.slave (config, TX/RX streams, status,   |
// |                      serial pins)                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int SYNC_STAGES = c_sync_stages
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    spi_slave_if.slave  bus
);

    localparam int                 c_cnt_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic w_sclk_s, w_ss_n_s, w_mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.sclk_i), .q_o(w_sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.ss_ni),  .q_o(w_ss_n_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.mosi_i), .q_o(w_mosi_s));

    // One extra registered copy of the synchronized levels for edge detection
    logic r_sclk_d, r_ss_n_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_d <= 1'b0;
            r_ss_n_d <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_n_d <= w_ss_n_s;
        end
    end

    logic w_rise, w_fall, w_lead, w_trail, w_sample_edge;
    assign w_rise        =  w_sclk_s & ~r_sclk_d;
    assign w_fall        = ~w_sclk_s &  r_sclk_d;
    assign w_lead        = bus.cpol_i ? w_fall : w_rise;
    assign w_trail       = bus.cpol_i ? w_rise : w_fall;
    assign w_sample_edge = bus.cpha_i ? w_trail : w_lead;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_rx_sr, r_rx_data, r_tx_sr, r_buf;
    logic               r_rx_valid, r_underrun, r_buf_full, r_miso;
    logic               w_load, w_sample, w_shift;
    logic [DATA_W-1:0]  w_rx_next;

    assign w_rx_next = {r_rx_sr[DATA_W-2:0], w_mosi_s};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_shift     = 1'b0;
        if (w_ss_n_s) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_ss_n_d) begin
                        w_state_nxt = SHIFT;
                        w_load      = 1'b1;
                    end
                end
                SHIFT: begin
                    w_sample = w_sample_edge;
                    w_load   = w_sample_edge && (r_bit_cnt == c_last_bit);
                    // CPHA=0: the trailing edge right after a byte-boundary load
                    // (counter back at 0) must not shift away the fresh MSB.
                    w_shift  = bus.cpha_i ? w_lead : (w_trail && (r_bit_cnt != '0));
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Receive path: partial bytes are dropped whenever ss_n goes high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_ss_n_s) begin
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
            end else if (w_sample) begin
                r_rx_sr <= w_rx_next;
                if (r_bit_cnt == c_last_bit) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_cnt_one;
                end
            end
        end
    end

    // Transmit path. CPHA=0 drives MISO straight from the register MSB;
    // CPHA=1 drives it from r_miso, updated on each leading edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_sr    <= '0;
            r_miso     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_tx_sr    <= r_buf_full ? r_buf : '0;
                r_underrun <= ~r_buf_full;
            end else if (w_shift) begin
                r_miso  <= r_tx_sr[DATA_W-1];
                r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Single-entry TX buffer; a write coinciding with a load is held for the
    // next load because the load always sees the pre-write state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (bus.tx_valid_i && !r_buf_full) begin
            r_buf      <= bus.tx_data_i;
            r_buf_full <= 1'b1;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    assign bus.tx_ready_o    = ~r_buf_full;
    assign bus.rx_data_o     = r_rx_data;
    assign bus.rx_valid_o    = r_rx_valid;
    assign bus.tx_underrun_o = r_underrun;
    assign bus.busy_o        = ~w_ss_n_s;
    assign bus.miso_oe_o     = ~w_ss_n_s;
    assign bus.miso_o        = bus.cpha_i ? r_miso : r_tx_sr[DATA_W-1];

endmodule
`default_nettype wire
